// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back arbiter: priority
// states, source identifiers and the grant-selection helper.
package wb_pkg;

    localparam logic PRI_NORMAL = 1'b0;
    localparam logic PRI_MD     = 1'b1;

    typedef enum logic {
        ST_NORMAL = PRI_NORMAL,
        ST_MD     = PRI_MD
    } pri_state_t;

    localparam logic [1:0] SRC_DM   = 2'd0;
    localparam logic [1:0] SRC_ALU  = 2'd1;
    localparam logic [1:0] SRC_MD   = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    localparam int GPR_ZERO = 0;

    // Normal order is dm > alu > md; a promoted md jumps ahead of both.
    function automatic logic [1:0] pick_src(input logic promote,
                                            input logic dm_v,
                                            input logic alu_v,
                                            input logic md_v);
        if (promote && md_v)
            return SRC_MD;
        else if (dm_v)
            return SRC_DM;
        else if (alu_v)
            return SRC_ALU;
        else if (md_v)
            return SRC_MD;
        else
            return SRC_NONE;
    endfunction

endpackage

// File: rtl/wb_starve_ctr.sv
// Starvation guard for the mul/div source: counts consecutive refused cycles
// and promotes md to top priority once the limit is reached.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_NORMAL | dm > alu > md, counting md refusals
//   ST_MD     | md promoted to top priority until it transfers or drops
module wb_starve_ctr
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_valid,
    input  logic md_ready,
    output logic md_promote
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    pri_state_t       state, state_next;
    logic [CNT_W-1:0] starve_cnt, cnt_next;
    logic             md_xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= cnt_next;
        end
    end

    // The promotion decision looks at the updated count, so md wins on the
    // cycle right after its last allowed refusal.
    always_comb begin
        md_xfer    = md_valid & md_ready;
        cnt_next   = starve_cnt;
        state_next = state;

        if (!md_valid || md_xfer)
            cnt_next = '0;
        else if (starve_cnt != CNT_MAX)
            cnt_next = starve_cnt + CNT_W'(1);

        case (state)
            ST_NORMAL: if (cnt_next == CNT_MAX) state_next = ST_MD;
            ST_MD:     if (md_xfer || !md_valid) state_next = ST_NORMAL;
            default:   state_next = ST_NORMAL;
        endcase
    end

    assign md_promote = (state == ST_MD);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU, load return
// and mul/div results; the write port itself is registered.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              dm_valid,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_data,
    output logic              dm_ready,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_stall
);

    logic              md_promote;
    logic [1:0]        src;
    logic              xfer;
    logic              do_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    wb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_promote (md_promote)
    );

    always_comb begin
        src      = pick_src(md_promote, dm_valid, alu_valid, md_valid);
        sel_addr = '0;
        sel_data = '0;
        case (src)
            SRC_DM:  begin sel_addr = dm_addr;  sel_data = dm_data;  end
            SRC_ALU: begin sel_addr = alu_addr; sel_data = alu_data; end
            SRC_MD:  begin sel_addr = md_addr;  sel_data = md_data;  end
            default: begin sel_addr = '0;       sel_data = '0;       end
        endcase
    end

    // Handshakes are held off entirely while reset is asserted.
    assign dm_ready  = reset & (src == SRC_DM);
    assign alu_ready = reset & (src == SRC_ALU);
    assign md_ready  = reset & (src == SRC_MD);
    assign wb_stall  = reset & ((alu_valid & ~alu_ready) | (dm_valid & ~dm_ready));

    assign xfer     = reset & (src != SRC_NONE);
    assign do_write = xfer & (sel_addr != ADDR_W'(GPR_ZERO));

    // r0 writes are accepted but never reach the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= do_write;
            if (do_write) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares each rf_we pulse.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, dm_valid, md_valid;
    logic [ADDR_W-1:0] alu_addr, dm_addr, md_addr;
    logic [DATA_W-1:0] alu_data, dm_data, md_data;
    logic              alu_ready, dm_ready, md_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_stall;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    wb_port_arbiter #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .dm_valid  (dm_valid),
        .dm_addr   (dm_addr),
        .dm_data   (dm_data),
        .dm_ready  (dm_ready),
        .md_valid  (md_valid),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wb_stall  (wb_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        dm_valid  = 1'b0;
        md_valid  = 1'b0;
    endtask

    // Monitor: every rf_we pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none at %0t",
                         rf_waddr, rf_wdata, $time);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(rf_waddr), 32'(w.addr));
                chk("wr_data", 32'(rf_wdata), 32'(w.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        idle();
        alu_addr = '0; alu_data = '0;
        dm_addr  = '0; dm_data  = '0;
        md_addr  = '0; md_data  = '0;
        tick();
        tick();
        #3 reset = 1'b1;

        // Reset values
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_state",    32'(dut.u_starve.state), 32'(PRI_NORMAL));

        // Mid-operation reset with all sources active: one dm write lands, the
        // transfer pending at reset time is lost.
        tick();
        dm_valid = 1'b1;  dm_addr = 3'd4;  dm_data = 16'hAAAA;
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h3333;
        md_valid = 1'b1;  md_addr = 3'd2;  md_data = 16'h2222;
        push(3'd4, 16'hAAAA);
        #1 chk("pre_rst_dm_ready", 32'(dm_ready), 32'd1);
        tick();
        #5 reset = 1'b0;
        #1;
        chk("in_rst_rf_we",     32'(rf_we),     32'd0);
        chk("in_rst_dm_ready",  32'(dm_ready),  32'd0);
        chk("in_rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("in_rst_md_ready",  32'(md_ready),  32'd0);
        chk("in_rst_wb_stall",  32'(wb_stall),  32'd0);
        tick();
        idle();
        #3 reset = 1'b1;
        #1;
        chk("post_rst_state", 32'(dut.u_starve.state),      32'(PRI_NORMAL));
        chk("post_rst_cnt",   32'(dut.u_starve.starve_cnt), 32'd0);
        chk("post_rst_rf_we", 32'(rf_we),                   32'd0);
        chk("post_rst_waddr", 32'(rf_waddr),                32'd0);

        // Priority: dm beats alu, alu follows next cycle
        tick();
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h1234;
        dm_valid  = 1'b1; dm_addr  = 3'd5; dm_data  = 16'hBEEF;
        push(3'd5, 16'hBEEF);
        push(3'd3, 16'h1234);
        #1;
        chk("pri_dm_ready",  32'(dm_ready),  32'd1);
        chk("pri_alu_ready", 32'(alu_ready), 32'd0);
        chk("pri_wb_stall",  32'(wb_stall),  32'd1);
        tick();
        dm_valid = 1'b0;
        #1;
        chk("pri2_alu_ready", 32'(alu_ready), 32'd1);
        chk("pri2_wb_stall",  32'(wb_stall),  32'd0);
        tick();
        idle();

        // Same destination from two sources: both writes happen, dm first
        tick();
        alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 16'h0A0A;
        dm_valid  = 1'b1; dm_addr  = 3'd6; dm_data  = 16'h0D0D;
        push(3'd6, 16'h0D0D);
        push(3'd6, 16'h0A0A);
        tick();
        dm_valid = 1'b0;
        tick();
        idle();

        // Starvation: md refused 4 times, granted on the 5th cycle
        for (int i = 1; i <= 5; i++) begin
            tick();
            alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h1000 + 16'(i);
            md_valid  = 1'b1; md_addr  = 3'd2; md_data  = 16'h0042;
            #1;
            chk($sformatf("starve_md_ready_%0d", i), 32'(md_ready), (i == 5) ? 32'd1 : 32'd0);
            if (i < 5)
                push(3'd1, 16'h1000 + 16'(i));
            else
                push(3'd2, 16'h0042);
        end
        chk("starve_wb_stall", 32'(wb_stall), 32'd1);
        tick();
        md_valid = 1'b0;
        push(3'd1, 16'h1005);
        #1;
        chk("starve_after_alu_ready", 32'(alu_ready), 32'd1);
        chk("starve_after_state", 32'(dut.u_starve.state),      32'(PRI_NORMAL));
        chk("starve_after_cnt",   32'(dut.u_starve.starve_cnt), 32'd0);
        tick();
        idle();

        // md drops while promoted: FSM returns to normal, count restarts
        for (int i = 1; i <= 4; i++) begin
            tick();
            alu_valid = 1'b1; alu_addr = 3'd7; alu_data = 16'h2000 + 16'(i);
            md_valid  = 1'b1; md_addr  = 3'd6; md_data  = 16'h0777;
            push(3'd7, 16'h2000 + 16'(i));
        end
        tick();
        md_valid = 1'b0;
        alu_data = 16'h2005;
        push(3'd7, 16'h2005);
        #1;
        chk("drop_state_md", 32'(dut.u_starve.state), 32'(PRI_MD));
        chk("drop_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        md_valid = 1'b1;
        alu_data = 16'h2006;
        push(3'd7, 16'h2006);
        #1;
        chk("drop_state_normal", 32'(dut.u_starve.state), 32'(PRI_NORMAL));
        chk("drop_md_refused",   32'(md_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        push(3'd6, 16'h0777);
        #1 chk("drop_md_alone_ready", 32'(md_ready), 32'd1);
        tick();
        idle();

        // r0 write accepted but suppressed
        tick();
        alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 16'hFFFF;
        #1 chk("r0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        #1 chk("r0_rf_we", 32'(rf_we), 32'd0);

        // Back-to-back ALU writes with no bubbles
        for (int i = 1; i <= 3; i++) begin
            tick();
            alu_valid = 1'b1; alu_addr = 3'(i); alu_data = 16'(i);
            push(3'(i), 16'(i));
            #1;
            chk($sformatf("b2b_ready_%0d", i), 32'(alu_ready), 32'd1);
            if (i > 1) begin
                chk($sformatf("b2b_we_%0d", i),    32'(rf_we),    32'd1);
                chk($sformatf("b2b_waddr_%0d", i), 32'(rf_waddr), 32'(i - 1));
            end
        end
        tick();
        idle();
        #1;
        chk("b2b_we_last",    32'(rf_we),    32'd1);
        chk("b2b_waddr_last", 32'(rf_waddr), 32'd3);
        tick();
        #1 chk("idle_rf_we", 32'(rf_we), 32'd0);
        chk("idle_hold_wdata", 32'(rf_wdata), 32'd3);

        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
